// File: rtl/video_timing_gen.sv
// Raster timing controller: HS/VS/DE, pixel coordinates and a pre-DE fetch strobe.
// Optional colour-bar generator enabled by VTG_TEST_PATTERN_EN.
module video_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0
) (
  input  logic        PixelClock,
  input  logic        Rst_n,
  input  logic        Enable,
  output logic        DataReq,
  output logic        H_Sync,
  output logic        V_Sync,
  output logic        DE,
  output logic [11:0] PixelX,
  output logic [11:0] PixelY,
  output logic        FrameStart,
  output logic        Busy
`ifdef VTG_TEST_PATTERN_EN
  ,
  output logic [7:0]  RedData,
  output logic [7:0]  GreenData,
  output logic [7:0]  BlueData
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] HA  = 12'(H_ACTIVE);
  localparam logic [11:0] HS0 = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS1 = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] HL  = 12'(H_TOTAL - 1);
  localparam logic [11:0] VA  = 12'(V_ACTIVE);
  localparam logic [11:0] VS0 = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS1 = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] VL  = 12'(V_TOTAL - 1);

  localparam logic ACT_LVL = (SYNC_POL != 0);
  localparam logic IDL_LVL = ~ACT_LVL;

  typedef enum logic {IDLE, RUN} state_e;

  state_e      state_q, state_d;
  logic [11:0] hcnt_q, hcnt_d;
  logic [11:0] vcnt_q, vcnt_d;
  logic        de_q, de_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic        fs_q, fs_d;
  logic [11:0] px_q, px_d;
  logic [11:0] py_q, py_d;
  logic        run, act, hs, vs, last;

  always_comb begin
    run  = (state_q == RUN);
    act  = (hcnt_q < HA) && (vcnt_q < VA);
    hs   = (hcnt_q >= HS0) && (hcnt_q < HS1);
    vs   = (vcnt_q >= VS0) && (vcnt_q < VS1);
    last = (hcnt_q == HL) && (vcnt_q == VL);

    state_d = state_q;
    hcnt_d  = hcnt_q;
    vcnt_d  = vcnt_q;
    unique case (state_q)
      IDLE: begin
        hcnt_d = '0;
        vcnt_d = '0;
        if (Enable) state_d = RUN;
      end
      RUN: begin
        if (hcnt_q == HL) begin
          hcnt_d = '0;
          vcnt_d = (vcnt_q == VL) ? 12'd0 : vcnt_q + 12'd1;
        end else begin
          hcnt_d = hcnt_q + 12'd1;
        end
        if (last && !Enable) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Everything below lags the decodes by one cycle, like DE.
    de_d = run && act;
    hs_d = (run && hs) ? ACT_LVL : IDL_LVL;
    vs_d = (run && vs) ? ACT_LVL : IDL_LVL;
    fs_d = run && (hcnt_q == 12'd0) && (vcnt_q == 12'd0);
    px_d = de_d ? hcnt_q : px_q;
    py_d = de_d ? vcnt_q : py_q;
  end

  always_ff @(posedge PixelClock or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      de_q    <= 1'b0;
      hs_q    <= IDL_LVL;
      vs_q    <= IDL_LVL;
      fs_q    <= 1'b0;
      px_q    <= '0;
      py_q    <= '0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      de_q    <= de_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      fs_q    <= fs_d;
      px_q    <= px_d;
      py_q    <= py_d;
    end
  end

  assign DataReq    = run && act;
  assign Busy       = run;
  assign DE         = de_q;
  assign H_Sync     = hs_q;
  assign V_Sync     = vs_q;
  assign FrameStart = fs_q;
  assign PixelX     = px_q;
  assign PixelY     = py_q;

`ifdef VTG_TEST_PATTERN_EN
  localparam logic [11:0] BAR_W = 12'(H_ACTIVE / 8);

  logic [2:0]  bar_idx_q, bar_idx_d;
  logic [11:0] bar_px_q, bar_px_d;
  logic [7:0]  r_q, r_d, g_q, g_d, b_q, b_d;

  // bar_idx_q/bar_px_q track the current hcnt; the last bar never advances.
  always_comb begin
    bar_idx_d = bar_idx_q;
    bar_px_d  = bar_px_q;
    if (hcnt_d == 12'd0) begin
      bar_idx_d = '0;
      bar_px_d  = '0;
    end else if (run && (hcnt_q < HA)) begin
      if ((bar_px_q == BAR_W - 12'd1) && (bar_idx_q != 3'd7)) begin
        bar_idx_d = bar_idx_q + 3'd1;
        bar_px_d  = '0;
      end else begin
        bar_px_d  = bar_px_q + 12'd1;
      end
    end
    r_d = de_d ? {8{~bar_idx_q[1]}} : 8'h00;
    g_d = de_d ? {8{~bar_idx_q[2]}} : 8'h00;
    b_d = de_d ? {8{~bar_idx_q[0]}} : 8'h00;
  end

  always_ff @(posedge PixelClock or negedge Rst_n) begin
    if (!Rst_n) begin
      bar_idx_q <= '0;
      bar_px_q  <= '0;
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
    end else begin
      bar_idx_q <= bar_idx_d;
      bar_px_q  <= bar_px_d;
      r_q       <= r_d;
      g_q       <= g_d;
      b_q       <= b_d;
    end
  end

  assign RedData   = r_q;
  assign GreenData = g_q;
  assign BlueData  = b_q;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: frame-position model with random Enable.
// Pattern outputs are checked when VTG_TEST_PATTERN_EN is defined.
module tb_video_timing_gen;

  localparam int HA = 8, HF = 2, HS = 3, HB = 3;
  localparam int VA = 4, VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        dreq, hsync, vsync, de, fs, busy;
  logic [11:0] px, py;
`ifdef VTG_TEST_PATTERN_EN
  logic [7:0]  rd, gd, bd;
`endif

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(0)
  ) dut (
    .PixelClock(clk),
    .Rst_n(rst_n),
    .Enable(en),
    .DataReq(dreq),
    .H_Sync(hsync),
    .V_Sync(vsync),
    .DE(de),
    .PixelX(px),
    .PixelY(py),
    .FrameStart(fs),
    .Busy(busy)
`ifdef VTG_TEST_PATTERN_EN
    ,
    .RedData(rd),
    .GreenData(gd),
    .BlueData(bd)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errs = 0;

  bit          m_run;
  int          m_pos;
  logic        e_de, e_hs, e_vs, e_fs;
  logic [11:0] e_px, e_py;
  logic [23:0] e_rgb;
  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit m_act(input int p);
    return ((p % HT) < HA) && ((p / HT) < VA);
  endfunction

  task automatic model_reset();
    m_run = 0; m_pos = 0;
    e_de = 0; e_hs = 1; e_vs = 1; e_fs = 0;
    e_px = 0; e_py = 0; e_rgb = 0;
  endtask

  task automatic model_edge(input logic e);
    int x, y, bi;
    x = m_pos % HT;
    y = m_pos / HT;
    e_de = m_run && m_act(m_pos);
    e_hs = !(m_run && x >= HA + HF && x < HA + HF + HS);
    e_vs = !(m_run && y >= VA + VF && y < VA + VF + VS);
    e_fs = m_run && m_pos == 0;
    if (e_de) begin
      e_px = 12'(x);
      e_py = 12'(y);
    end
    bi = x / (HA / 8);
    if (bi > 7) bi = 7;
    e_rgb = e_de ? bars[bi] : 24'h0;
    if (!m_run) begin
      if (e) begin m_run = 1; m_pos = 0; end
    end else if (m_pos == FT - 1 && !e) begin
      m_run = 0; m_pos = 0;
    end else begin
      m_pos = (m_pos + 1) % FT;
    end
  endtask

  task automatic check_all(input string ph);
    chk({ph, ".de"}, 32'(de), 32'(e_de));
    chk({ph, ".hsync"}, 32'(hsync), 32'(e_hs));
    chk({ph, ".vsync"}, 32'(vsync), 32'(e_vs));
    chk({ph, ".fstart"}, 32'(fs), 32'(e_fs));
    chk({ph, ".px"}, 32'(px), 32'(e_px));
    chk({ph, ".py"}, 32'(py), 32'(e_py));
    chk({ph, ".busy"}, 32'(busy), 32'(m_run));
    chk({ph, ".dreq"}, 32'(dreq), 32'(m_run && m_act(m_pos)));
`ifdef VTG_TEST_PATTERN_EN
    chk({ph, ".rgb"}, 32'({rd, gd, bd}), 32'(e_rgb));
`endif
  endtask

  task automatic cyc(input string ph, input logic e);
    en = e;
    @(posedge clk);
    model_edge(e);
    @(negedge clk);
    check_all(ph);
  endtask

  initial begin
    int de_cnt, fs_cnt, hs_cnt;
    logic rnd_en;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    repeat (50) cyc("idle", 1'b0);

    // Start: DataReq right after the enabling edge, DE one cycle later.
    cyc("start", 1'b1);
    chk("start.dreq_k", 32'(dreq), 32'd1);
    chk("start.de_k", 32'(de), 32'd0);
    cyc("start1", 1'b1);
    chk("start.fs_k1", 32'(fs), 32'd1);
    chk("start.de_k1", 32'(de), 32'd1);

    de_cnt = 0; fs_cnt = 0; hs_cnt = 0;
    for (int i = 0; i < 2 * FT; i++) begin
      cyc("run", 1'b1);
      de_cnt += int'(de);
      fs_cnt += int'(fs);
      hs_cnt += int'(!hsync);
    end
    chk("run.de_count", 32'(de_cnt), 32'(2 * HA * VA));
    chk("run.fs_count", 32'(fs_cnt), 32'd2);
    chk("run.hs_count", 32'(hs_cnt), 32'(2 * HS * VT));

    // Drop Enable at VCnt=1: the frame still finishes.
    for (int i = 0; i < 2 * FT && !(m_run && m_pos == HT); i++)
      cyc("seek1", 1'b1);
    chk("seek1.reached", 32'(m_run && m_pos == HT), 32'd1);
    de_cnt = 0;
    for (int i = 0; i < 200; i++) begin
      cyc("stop", 1'b0);
      de_cnt += int'(de);
    end
    chk("stop.de_rest", 32'(de_cnt), 32'(HA * (VA - 1)));
    chk("stop.busy", 32'(busy), 32'd0);

    rnd_en = 1'b0;
    repeat (1000) begin
      if ($urandom_range(0, 31) == 0) rnd_en = ~rnd_en;
      cyc("rand", rnd_en);
    end

    // Async reset at VCnt=2, HCnt=3.
    for (int i = 0; i < 3 * FT && !(m_run && m_pos == 2 * HT + 3); i++)
      cyc("seek2", 1'b1);
    chk("seek2.reached", 32'(m_run && m_pos == 2 * HT + 3), 32'd1);
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all("areset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) cyc("post_rst", 1'b0);
    cyc("restart", 1'b1);
    cyc("restart1", 1'b1);
    chk("restart.fs", 32'(fs), 32'd1);
    chk("restart.xy", 32'({px, py}), 32'd0);
    repeat (300) cyc("run2", 1'b1);
    repeat (200) cyc("tail", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
